// File: rtl/interp_pkg.sv
// Shared geometry and row type for the reference loader and interpolator.
package interp_pkg;

  localparam int unsigned ROWS      = 15;
  localparam int unsigned COLS      = 15;
  localparam int unsigned PIX_W     = 8;
  localparam int unsigned ROW_W     = COLS * PIX_W;
  localparam int unsigned ROW_IDX_W = 4;
  localparam int unsigned COL_IDX_W = 4;
  localparam int unsigned SEL_W     = 8;

  typedef logic [ROW_W-1:0] row_t;

endpackage

// File: rtl/ref_row_bank.sv
// One bank of ROWS row registers: pixel-granular write, whole-row combinational read.
module ref_row_bank
  import interp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ROW_IDX_W-1:0] wr_row,
  input  logic [COL_IDX_W-1:0] wr_col,
  input  logic [PIX_W-1:0]     wr_pix,
  input  logic [SEL_W-1:0]     rd_idx,
  output row_t                 rd_row
);

  row_t rows [ROWS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) rows[r] <= '0;
    end else if (wr_en) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (wr_row == ROW_IDX_W'(r) && wr_col == COL_IDX_W'(c))
            rows[r][c*PIX_W +: PIX_W] <= wr_pix;
        end
      end
    end
  end

  // Out-of-range row indices read as zero.
  always_comb begin
    rd_row = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (rd_idx == SEL_W'(r)) rd_row = rows[r];
    end
  end

endmodule

// File: rtl/ref_block_loader.sv
// Double-buffered 15x15 reference block loader: raster pixel writes, whole-row reads by index.
module ref_block_loader
  import interp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [SEL_W-1:0] row_idx,
  output row_t             out_row,
  output logic             blk_valid,
  output logic             blk_start,
  input  logic             blk_done
);

  localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(ROWS - 1);
  localparam logic [COL_IDX_W-1:0] LAST_COL = COL_IDX_W'(COLS - 1);

  logic [1:0]           full;
  logic [1:0]           full_nxt;
  logic                 wr_bank;
  logic                 rd_bank;
  logic [ROW_IDX_W-1:0] wr_row;
  logic [COL_IDX_W-1:0] wr_col;
  logic                 started;

  logic accept;
  logic fill_done;
  logic blk_release;
  row_t bank_row [2];

  assign pix_ready   = !full[wr_bank];
  assign accept      = pix_valid && pix_ready;
  assign fill_done   = accept && (wr_row == LAST_ROW) && (wr_col == LAST_COL);
  assign blk_valid   = full[rd_bank];
  assign blk_release = blk_done && blk_valid;
  assign blk_start   = blk_valid && !started;
  assign out_row     = bank_row[rd_bank];

  // Fill and release always target different banks, so both updates can apply together.
  always_comb begin
    full_nxt = full;
    if (fill_done)   full_nxt[wr_bank] = 1'b1;
    if (blk_release) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_row  <= '0;
      wr_col  <= '0;
      started <= 1'b0;
    end else begin
      full <= full_nxt;
      if (accept) begin
        if (wr_col == LAST_COL) begin
          wr_col <= '0;
          if (wr_row == LAST_ROW) begin
            wr_row  <= '0;
            wr_bank <= ~wr_bank;
          end else begin
            wr_row <= wr_row + ROW_IDX_W'(1);
          end
        end else begin
          wr_col <= wr_col + COL_IDX_W'(1);
        end
      end
      if (blk_release) begin
        rd_bank <= ~rd_bank;
        started <= 1'b0;
      end else if (blk_start) begin
        started <= 1'b1;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    ref_row_bank u_bank (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (accept && (wr_bank == 1'(b))),
      .wr_row (wr_row),
      .wr_col (wr_col),
      .wr_pix (pix_in),
      .rd_idx (row_idx),
      .rd_row (bank_row[b])
    );
  end

endmodule

// File: tb/tb_ref_block_loader.sv
// Scoreboard bench for ref_block_loader: expected rows queued as pixels are accepted, popped on read.
module tb_ref_block_loader;
  import interp_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [PIX_W-1:0] pix_in = '0;
  logic             pix_valid = 1'b0;
  logic             pix_ready;
  logic [SEL_W-1:0] row_idx = '0;
  row_t             out_row;
  logic             blk_valid;
  logic             blk_start;
  logic             blk_done = 1'b0;

  int   errors = 0;
  int   checks = 0;
  row_t sb [$];

  ref_block_loader dut (
    .clk       (clk),
    .rst       (rst),
    .pix_in    (pix_in),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .row_idx   (row_idx),
    .out_row   (out_row),
    .blk_valid (blk_valid),
    .blk_start (blk_start),
    .blk_done  (blk_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] pix_val(input int kind, input int r, input int c);
    logic [7:0] base;
    base = 8'(16 * r + c);
    case (kind)
      1:       return 8'hFF - base;
      2:       return base ^ 8'h5A;
      default: return base;
    endcase
  endfunction

  // Streams n accepted pixels; queues each completed row. Reports blk_start pulses
  // and whether blk_valid was seen before the final accept.
  task automatic stream(input int kind, input int n, input int gate_pct,
                        output int starts, output bit early_valid);
    int   k = 0;
    int   cyc = 0;
    int   r, c;
    bit   g, rdy;
    row_t cur = '0;
    starts = 0;
    early_valid = 1'b0;
    while (k < n && cyc < 4000) begin
      r = (k / COLS) % ROWS;
      c = k % COLS;
      g = ($urandom_range(99) < gate_pct);
      pix_valid = g;
      pix_in = pix_val(kind, r, c);
      rdy = pix_ready;
      @(posedge clk); #1;
      cyc++;
      if (blk_start === 1'b1) starts++;
      if (g && rdy) begin
        cur[c*PIX_W +: PIX_W] = pix_val(kind, r, c);
        if (c == COLS - 1) sb.push_back(cur);
        k++;
      end
      if (k < n && blk_valid !== 1'b0) early_valid = 1'b1;
    end
    pix_valid = 1'b0;
    if (k < n) begin
      errors++; checks++;
      $display("FAIL stream_timeout: accepted %0d of %0d pixels", k, n);
    end
  endtask

  task automatic pulse_done();
    blk_done = 1'b1;
    @(posedge clk); #1;
    blk_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL reset_pix_ready: got %b want 1", pix_ready); end
    checks++; if (blk_valid !== 1'b0) begin errors++; $display("FAIL reset_blk_valid: got %b want 0", blk_valid); end
    checks++; if (blk_start !== 1'b0) begin errors++; $display("FAIL reset_blk_start: got %b want 0", blk_start); end
    for (int r = 0; r < ROWS; r++) begin
      row_idx = SEL_W'(r);
      @(negedge clk);
      checks++;
      if (out_row !== '0) begin errors++; $display("FAIL reset_out_row[%0d]: got %h want 0", r, out_row); end
    end
  endtask

  task automatic test_single_block();
    int   starts;
    bit   early;
    row_t exp;
    stream(0, ROWS * COLS, 100, starts, early);
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", early); end
    checks++; if (blk_valid !== 1'b1) begin errors++; $display("FAIL single_blk_valid: got %b want 1", blk_valid); end
    checks++; if (blk_start !== 1'b1) begin errors++; $display("FAIL single_blk_start: got %b want 1", blk_start); end
    @(posedge clk); #1;
    checks++; if (blk_start !== 1'b0) begin errors++; $display("FAIL single_start_width: got %b want 0", blk_start); end
    for (int r = 0; r < ROWS; r++) begin
      row_idx = SEL_W'(r);
      @(negedge clk);
      exp = (sb.size() > 0) ? sb.pop_front() : 'x;
      checks++;
      if (out_row !== exp) begin errors++; $display("FAIL single_row[%0d]: got %h want %h", r, out_row, exp); end
    end
    pulse_done();
    checks++; if (blk_valid !== 1'b0) begin errors++; $display("FAIL single_release: got %b want 0", blk_valid); end
  endtask

  task automatic test_back_pressure();
    int   starts;
    bit   early;
    bit   moved = 1'b0;
    row_t exp;
    row_t snap;
    stream(0, ROWS * COLS, 100, starts, early);
    stream(1, ROWS * COLS, 100, starts, early);
    checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL bp_stalled: got pix_ready %b want 0", pix_ready); end
    row_idx = 8'd0;
    #1 snap = out_row;
    for (int i = 0; i < 50; i++) begin
      pix_valid = 1'b1;
      pix_in = 8'hAA;
      @(posedge clk); #1;
      if (pix_ready !== 1'b0 || blk_start !== 1'b0 || blk_valid !== 1'b1 || out_row !== snap) moved = 1'b1;
    end
    pix_valid = 1'b0;
    checks++; if (moved !== 1'b0) begin errors++; $display("FAIL bp_ignored: state changed %b want 0", moved); end
    for (int r = 0; r < ROWS; r++) begin
      row_idx = SEL_W'(r);
      @(negedge clk);
      exp = (sb.size() > 0) ? sb.pop_front() : 'x;
      checks++;
      if (out_row !== exp) begin errors++; $display("FAIL bp_blk1_row[%0d]: got %h want %h", r, out_row, exp); end
    end
    pulse_done();
    checks++; if (blk_valid !== 1'b1) begin errors++; $display("FAIL bp_swap_valid: got %b want 1", blk_valid); end
    checks++; if (blk_start !== 1'b1) begin errors++; $display("FAIL bp_swap_start: got %b want 1", blk_start); end
    checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b want 1", pix_ready); end
    @(posedge clk); #1;
    checks++; if (blk_start !== 1'b0) begin errors++; $display("FAIL bp_start_width: got %b want 0", blk_start); end
    for (int r = 0; r < ROWS; r++) begin
      row_idx = SEL_W'(r);
      @(negedge clk);
      exp = (sb.size() > 0) ? sb.pop_front() : 'x;
      checks++;
      if (out_row !== exp) begin errors++; $display("FAIL bp_blk2_row[%0d]: got %h want %h", r, out_row, exp); end
    end
    pulse_done();
    checks++; if (blk_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b want 0", blk_valid); end
  endtask

  task automatic test_bubbles();
    int   starts;
    bit   early;
    row_t exp;
    stream(0, ROWS * COLS, 50, starts, early);
    repeat (5) begin
      @(posedge clk); #1;
      if (blk_start === 1'b1) starts++;
    end
    checks++; if (starts !== 1) begin errors++; $display("FAIL bubbles_start_count: got %0d want 1", starts); end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL bubbles_early_valid: got %b want 0", early); end
    for (int r = 0; r < ROWS; r++) begin
      row_idx = SEL_W'(r);
      @(negedge clk);
      exp = (sb.size() > 0) ? sb.pop_front() : 'x;
      checks++;
      if (out_row !== exp) begin errors++; $display("FAIL bubbles_row[%0d]: got %h want %h", r, out_row, exp); end
    end
    pulse_done();
  endtask

  task automatic test_reset_mid_fill();
    int   starts;
    bit   early;
    row_t exp;
    stream(1, 100, 100, starts, early);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    checks++; if (pix_ready !== 1'b1 || blk_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_async: got ready %b valid %b want 1 0", pix_ready, blk_valid);
    end
    @(posedge clk); #1 rst = 1'b0;
    stream(2, ROWS * COLS, 100, starts, early);
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL midrst_early_valid: got %b want 0", early); end
    checks++; if (blk_valid !== 1'b1 || blk_start !== 1'b1) begin
      errors++; $display("FAIL midrst_complete: got valid %b start %b want 1 1", blk_valid, blk_start);
    end
    for (int r = 0; r < ROWS; r++) begin
      row_idx = SEL_W'(r);
      @(negedge clk);
      exp = (sb.size() > 0) ? sb.pop_front() : 'x;
      checks++;
      if (out_row !== exp) begin errors++; $display("FAIL midrst_row[%0d]: got %h want %h", r, out_row, exp); end
    end
    row_idx = 8'd15;
    @(negedge clk);
    checks++; if (out_row !== '0) begin errors++; $display("FAIL edge_row15: got %h want 0", out_row); end
    row_idx = 8'd255;
    @(negedge clk);
    checks++; if (out_row !== '0) begin errors++; $display("FAIL edge_row255: got %h want 0", out_row); end
    pulse_done();
  endtask

  task automatic test_edge_release();
    int   starts;
    bit   early;
    row_t exp;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    pulse_done();
    checks++; if (blk_valid !== 1'b0 || pix_ready !== 1'b1 || blk_start !== 1'b0) begin
      errors++; $display("FAIL edge_idle_done: got valid %b ready %b start %b want 0 1 0", blk_valid, pix_ready, blk_start);
    end
    stream(0, ROWS * COLS, 100, starts, early);
    checks++; if (blk_valid !== 1'b1 || blk_start !== 1'b1) begin
      errors++; $display("FAIL edge_after_done: got valid %b start %b want 1 1", blk_valid, blk_start);
    end
    for (int r = 0; r < ROWS; r++) begin
      row_idx = SEL_W'(r);
      @(negedge clk);
      exp = (sb.size() > 0) ? sb.pop_front() : 'x;
      checks++;
      if (out_row !== exp) begin errors++; $display("FAIL edge_row[%0d]: got %h want %h", r, out_row, exp); end
    end
    pulse_done();
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_back_pressure();
    test_bubbles();
    test_reset_mid_fill();
    test_edge_release();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
